// File: rtl/pe_fx_bank.sv
// Systolic fixed-point MAC processing element with a selectable coefficient bank.
// partial_out = left_in + round((coef * top_in) >>> FRAC_BITS), two pipeline stages.
module pe_fx_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int COEF_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int NUM_COEF   = 4,
  parameter int ROUND      = 1,
  parameter int SATURATE   = 1,
  localparam int AW = $clog2(NUM_COEF)
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         coef_we,
  input  logic [AW-1:0]                coef_waddr,
  input  logic signed [COEF_WIDTH-1:0] coef_wdata,
  input  logic [AW-1:0]                coef_sel,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] top_in,
  input  logic signed [OUT_WIDTH-1:0]  left_in,
  output logic signed [DATA_WIDTH-1:0] down_out,
  output logic                         down_valid,
  output logic signed [OUT_WIDTH-1:0]  partial_out,
  output logic                         out_valid,
  output logic                         ovf_flag
);

  localparam int PW  = COEF_WIDTH + DATA_WIDTH;
  localparam int SW  = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 2;
  localparam int RSH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [SW-1:0] RND  =
    (ROUND != 0 && FRAC_BITS > 0) ? (SW'(1) <<< RSH) : '0;
  localparam logic signed [SW-1:0] OMAX = (SW'(1) <<< (OUT_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] OMIN = -(SW'(1) <<< (OUT_WIDTH - 1));

  function automatic logic signed [SW-1:0] round_shift(input logic signed [PW-1:0] prod);
    logic signed [SW-1:0] ext;
    ext = {{(SW-PW){prod[PW-1]}}, prod};
    return (ext + RND) >>> FRAC_BITS;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [SW-1:0] s);
    if (SATURATE != 0 && s > OMAX) return OMAX[OUT_WIDTH-1:0];
    if (SATURATE != 0 && s < OMIN) return OMIN[OUT_WIDTH-1:0];
    return s[OUT_WIDTH-1:0];
  endfunction

  logic signed [COEF_WIDTH-1:0] bank_q [NUM_COEF];
  logic signed [COEF_WIDTH-1:0] bank_d [NUM_COEF];
  logic signed [PW-1:0]         prod_p1_q, prod_p1_d;
  logic signed [OUT_WIDTH-1:0]  left_p1_q, left_p1_d;
  logic                         vld_p1_q, vld_p1_d;
  logic signed [DATA_WIDTH-1:0] down_p1_q, down_p1_d;
  logic                         down_vld_p1_q, down_vld_p1_d;
  logic signed [OUT_WIDTH-1:0]  part_p2_q, part_p2_d;
  logic                         vld_p2_q, vld_p2_d;
  logic                         ovf_q, ovf_d;

  logic signed [COEF_WIDTH-1:0] coef_rd;
  logic signed [PW-1:0]         coef_ext, top_ext;
  logic signed [SW-1:0]         sum_p2;
  logic                         ovf_p2;

  // Stage 1 operands: the bank is read from the register, so a same-cycle write is not seen.
  assign coef_rd  = bank_q[coef_sel];
  assign coef_ext = {{DATA_WIDTH{coef_rd[COEF_WIDTH-1]}}, coef_rd};
  assign top_ext  = {{COEF_WIDTH{top_in[DATA_WIDTH-1]}}, top_in};

  // Stage 2 sum at full width, range-checked before narrowing.
  assign sum_p2 = $signed({{(SW-OUT_WIDTH){left_p1_q[OUT_WIDTH-1]}}, left_p1_q})
                + round_shift(prod_p1_q);
  assign ovf_p2 = (sum_p2 > OMAX) || (sum_p2 < OMIN);

  always_comb begin
    bank_d        = bank_q;
    prod_p1_d     = prod_p1_q;
    left_p1_d     = left_p1_q;
    vld_p1_d      = 1'b0;
    down_p1_d     = down_p1_q;
    down_vld_p1_d = 1'b0;
    part_p2_d     = part_p2_q;
    vld_p2_d      = 1'b0;
    ovf_d         = ovf_q;
    if (coef_we) bank_d[coef_waddr] = coef_wdata;
    if (clear) begin
      ovf_d = 1'b0;
    end else begin
      if (in_valid) begin
        prod_p1_d     = coef_ext * top_ext;
        left_p1_d     = left_in;
        vld_p1_d      = 1'b1;
        down_p1_d     = top_in;
        down_vld_p1_d = 1'b1;
      end
      if (vld_p1_q) begin
        part_p2_d = saturate(sum_p2);
        vld_p2_d  = 1'b1;
        if (ovf_p2) ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_COEF; i++) bank_q[i] <= '0;
      prod_p1_q     <= '0;
      left_p1_q     <= '0;
      vld_p1_q      <= 1'b0;
      down_p1_q     <= '0;
      down_vld_p1_q <= 1'b0;
      part_p2_q     <= '0;
      vld_p2_q      <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      prod_p1_q     <= prod_p1_d;
      left_p1_q     <= left_p1_d;
      vld_p1_q      <= vld_p1_d;
      down_p1_q     <= down_p1_d;
      down_vld_p1_q <= down_vld_p1_d;
      part_p2_q     <= part_p2_d;
      vld_p2_q      <= vld_p2_d;
      ovf_q         <= ovf_d;
    end
  end

  assign down_out    = down_p1_q;
  assign down_valid  = down_vld_p1_q;
  assign partial_out = part_p2_q;
  assign out_valid   = vld_p2_q;
  assign ovf_flag    = ovf_q;

endmodule

// File: tb/tb_pe_fx_bank.sv
// Scoreboard bench for pe_fx_bank: a reference model queues expected partial sums
// at drive time; a negedge monitor pops them when out_valid is seen.
module tb_pe_fx_bank;

  localparam int DW = 16;
  localparam int OW = 16;
  localparam int CW = 32;
  localparam int FRAC = 16;
  localparam int NC = 4;
  localparam int RND_EN = 1;
  localparam int SAT_EN = 1;

  logic                 clk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 coef_we = 1'b0;
  logic [1:0]           coef_waddr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic [1:0]           coef_sel = '0;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] top_in = '0;
  logic signed [OW-1:0] left_in = '0;
  logic signed [DW-1:0] down_out;
  logic                 down_valid;
  logic signed [OW-1:0] partial_out;
  logic                 out_valid;
  logic                 ovf_flag;

  int checks = 0;
  int errors = 0;
  logic signed [OW-1:0] sb[$];
  longint mbank[NC] = '{0, 0, 0, 0};

  pe_fx_bank #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .COEF_WIDTH(CW), .FRAC_BITS(FRAC),
    .NUM_COEF(NC), .ROUND(RND_EN), .SATURATE(SAT_EN)
  ) dut (
    .clk(clk), .aresetn(aresetn), .coef_we(coef_we), .coef_waddr(coef_waddr),
    .coef_wdata(coef_wdata), .coef_sel(coef_sel), .clear(clear), .in_valid(in_valid),
    .top_in(top_in), .left_in(left_in), .down_out(down_out), .down_valid(down_valid),
    .partial_out(partial_out), .out_valid(out_valid), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  function automatic logic signed [OW-1:0] model(input longint c, input longint t, input longint l);
    longint p, r, s;
    p = c * t;
    r = (p + ((RND_EN != 0) ? 64'sd32768 : 64'sd0)) >>> FRAC;
    s = l + r;
    if (SAT_EN != 0 && s > 32767) return 16'sh7fff;
    if (SAT_EN != 0 && s < -32768) return 16'sh8000;
    return 16'(s);
  endfunction

  // Scoreboard monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (aresetn && out_valid) begin
      logic signed [OW-1:0] exp_v;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: out_valid with partial_out=%0d, expected no output", partial_out);
      end else begin
        exp_v = sb.pop_front();
        if (partial_out !== exp_v) begin
          errors++;
          $display("FAIL sb_partial: partial_out=%0d expected=%0d", partial_out, exp_v);
        end
      end
    end
  end

  task automatic step(input bit we, input logic [1:0] wa, input logic [31:0] wd,
                      input bit vld, input logic [1:0] s, input int top, input int left,
                      input bit clr);
    coef_we = we; coef_waddr = wa; coef_wdata = wd;
    in_valid = vld; coef_sel = s; top_in = 16'(top); left_in = 16'(left); clear = clr;
    if (vld && !clr) sb.push_back(model(mbank[s], longint'(top), longint'(left)));
    if (we) mbank[wa] = longint'($signed(wd));
    @(posedge clk); #1;
    coef_we = 1'b0; in_valid = 1'b0; clear = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) if (sb.size() != 0) idle();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (partial_out !== '0) begin errors++; $display("FAIL rst_partial: got %0d want 0", partial_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (down_out !== '0) begin errors++; $display("FAIL rst_down: got %0d want 0", down_out); end
    checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL rst_down_valid: got %b want 0", down_valid); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf_flag); end
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    step(1, 0, 32'h0001_8000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 100, 10, 0);
    checks++; if (down_out !== 16'sd100) begin errors++; $display("FAIL basic_down: got %0d want 100", down_out); end
    checks++; if (down_valid !== 1'b1) begin errors++; $display("FAIL basic_down_valid: got %b want 1", down_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    idle();
    checks++; if (partial_out !== 16'sd160) begin errors++; $display("FAIL basic_partial: got %0d want 160", partial_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    checks++; if (down_valid !== 1'b0 || down_out !== 16'sd100) begin
      errors++; $display("FAIL basic_down_hold: got %0d/%b want 100/0", down_out, down_valid); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf_flag); end
    drain();
  endtask

  task automatic test_rounding();
    logic signed [OW-1:0] e_pos, e_neg;
    e_pos = (RND_EN != 0) ? 16'sd2 : 16'sd1;
    e_neg = (RND_EN != 0) ? -16'sd1 : -16'sd2;
    step(1, 1, 32'h0000_8000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 3, 0, 0);
    step(0, 0, 0, 1, 1, -3, 0, 0);
    checks++; if (partial_out !== e_pos) begin errors++; $display("FAIL round_pos: got %0d want %0d", partial_out, e_pos); end
    idle();
    checks++; if (partial_out !== e_neg) begin errors++; $display("FAIL round_neg: got %0d want %0d", partial_out, e_neg); end
    drain();
  endtask

  task automatic test_saturation();
    step(1, 2, 32'h7FFF_0000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 2, 0, 0);
    idle();
    checks++; if (partial_out !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", partial_out); end
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL sat_ovf_set: got %b want 1", ovf_flag); end
    step(1, 3, 32'hFFFF_0000, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 3, 1, -32768, 0);
    idle();
    checks++; if (partial_out !== -16'sd32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", partial_out); end
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky: got %b want 1", ovf_flag); end
    drain();
  endtask

  task automatic test_back_to_back();
    bit vpat[13];
    step(1, 0, 32'h0001_0000, 0, 0, 0, 0, 0);
    step(1, 1, 32'h0002_0000, 0, 0, 0, 0, 0);
    step(1, 2, 32'hFFFF_0000, 0, 0, 0, 0, 0);
    step(1, 3, 32'h0000_8000, 0, 0, 0, 0, 0);
    for (int j = 0; j < 13; j++) vpat[j] = (j < 8) || (j == 9) || (j == 10);
    for (int j = 0; j < 13; j++) begin
      step(0, 0, 0, vpat[j], 2'(j % 4), 40, 0, 0);
      if (j >= 1) begin
        checks++;
        if (out_valid !== vpat[j-1]) begin
          errors++; $display("FAIL stream_valid[%0d]: got %b want %b", j, out_valid, vpat[j-1]);
        end
      end
      if (j == 9) begin
        checks++;
        if (partial_out !== 16'sd20) begin
          errors++; $display("FAIL stream_bubble_hold: got %0d want 20", partial_out);
        end
      end
    end
    drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL stream_drain: %0d outputs missing, want 0", sb.size()); end
  endtask

  task automatic test_collision();
    step(1, 0, 32'h0001_0000, 0, 0, 0, 0, 0);
    step(1, 0, 32'h0003_0000, 1, 0, 5, 0, 0);
    step(0, 0, 0, 1, 0, 5, 0, 0);
    checks++; if (partial_out !== 16'sd5) begin errors++; $display("FAIL collide_old: got %0d want 5", partial_out); end
    idle();
    checks++; if (partial_out !== 16'sd15) begin errors++; $display("FAIL collide_new: got %0d want 15", partial_out); end
    drain();
  endtask

  task automatic test_clear();
    checks++; if (ovf_flag !== 1'b1) begin errors++; $display("FAIL clear_pre_ovf: got %b want 1", ovf_flag); end
    step(0, 0, 0, 1, 0, 7, 1, 0);
    step(1, 1, 32'h0004_0000, 1, 0, 9, 2, 1);
    sb.delete();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid: got %b want 0", out_valid); end
    checks++; if (down_valid !== 1'b0 || down_out !== 16'sd7) begin
      errors++; $display("FAIL clear_down: got %0d/%b want 7/0", down_out, down_valid); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL clear_ovf: got %b want 0", ovf_flag); end
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_pulse[%0d]: got %b want 0", i, out_valid); end
    end
    step(0, 0, 0, 1, 1, 10, 0, 0);
    step(0, 0, 0, 1, 0, 9, 0, 0);
    idle();
    checks++; if (partial_out !== 16'sd27) begin errors++; $display("FAIL clear_bank_kept: got %0d want 27", partial_out); end
    drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL clear_drain: %0d outputs missing, want 0", sb.size()); end
  endtask

  task automatic test_async_reset();
    step(0, 0, 0, 1, 0, 2, 0, 0);
    step(0, 0, 0, 1, 1, 3, 0, 0);
    aresetn = 1'b0;
    #2;
    checks++; if (partial_out !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL areset_out: got %0d/%b want 0/0", partial_out, out_valid); end
    checks++; if (down_out !== '0 || down_valid !== 1'b0) begin
      errors++; $display("FAIL areset_down: got %0d/%b want 0/0", down_out, down_valid); end
    checks++; if (ovf_flag !== 1'b0) begin errors++; $display("FAIL areset_ovf: got %b want 0", ovf_flag); end
    sb.delete();
    for (int i = 0; i < NC; i++) mbank[i] = 0;
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    step(0, 0, 0, 1, 0, 50, 3, 0);
    step(0, 0, 0, 1, 1, 50, -4, 0);
    idle();
    checks++; if (partial_out !== -16'sd4) begin errors++; $display("FAIL areset_bank_zero: got %0d want -4", partial_out); end
    drain();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL areset_drain: %0d outputs missing, want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_collision();
    test_clear();
    test_async_reset();
    repeat (2) idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_fx_bank.md
Name: pe_fx_bank

Overview:
Next-generation systolic multiply-accumulate processing element for the Horner/matrix array. It is a fixed-point PE: `partial_out = left_in + ((coef * top_in) >>> FRAC_BITS)`.
- Adds a multi-entry coefficient bank with per-cycle selection, so one array pass can step through polynomial or matrix coefficients.
- Adds valid propagation, optional rounding and optional saturation with an overflow flag.
- Two-stage pipeline; tiles in a 2-D grid like its predecessor (`top`→`down`, `left`→`partial`).

Parameters:
- DATA_WIDTH, 16: signed width of `top_in`/`down_out`.
- OUT_WIDTH, 16: signed width of `left_in`/`partial_out`.
- COEF_WIDTH, 32: signed coefficient width.
- FRAC_BITS, 16: arithmetic right shift applied to the product (Q-format fraction bits); 0 is legal.
- NUM_COEF, 4: coefficient bank depth; power of two, ≥2. `AW = log2(NUM_COEF)`.
- ROUND, 1: 1 = round half up (add 2^(FRAC_BITS-1) before shift); 0 = floor. Ignored when FRAC_BITS = 0.
- SATURATE, 1: 1 = clamp the sum to the OUT_WIDTH signed range; 0 = wrap (keep the low OUT_WIDTH bits).

Ports:
- clk, in, 1: clock.
- aresetn, in, 1: asynchronous active-low reset.
- coef_we, in, 1: write bank entry `coef_waddr` with `coef_wdata`.
- coef_waddr, in, AW: bank write address.
- coef_wdata, in, COEF_WIDTH: signed coefficient.
- coef_sel, in, AW: bank entry used for the current `in_valid` sample.
- clear, in, 1: synchronous pipeline flush plus `ovf_flag` clear.
- in_valid, in, 1: `top_in`/`left_in`/`coef_sel` are valid this cycle.
- top_in, in, DATA_WIDTH: signed operand from the PE above.
- left_in, in, OUT_WIDTH: signed partial sum from the PE to the left.
- down_out, out, DATA_WIDTH: `top_in` forwarded to the PE below.
- down_valid, out, 1: qualifies `down_out`.
- partial_out, out, OUT_WIDTH: signed result to the PE on the right.
- out_valid, out, 1: qualifies `partial_out`.
- ovf_flag, out, 1: sticky; set when any result exceeded the OUT_WIDTH signed range.

Behaviour:
- **Reset** (`aresetn` low, asynchronous): every register is cleared to 0. This covers all bank entries, both pipeline stages, `down_out`, `down_valid`, `partial_out`, `out_valid` and `ovf_flag`. Reset mid-operation discards all in-flight samples.
- **Bank write:** on a clock edge with `coef_we` = 1, `bank[coef_waddr] <= coef_wdata`. The write is independent of `in_valid`.
  - Read/write collision on the same address in the same cycle: stage 1 uses the OLD value; the new value is visible from the next cycle.
- **Forward path** (latency 1):
  - On `in_valid` = 1: `down_out <= top_in`, `down_valid <= 1`.
  - Otherwise: `down_out` holds, `down_valid <= 0`.
- **Stage 1** (on `in_valid` = 1):
  - `prod1 <= signed(bank[coef_sel]) * signed(top_in)`, full COEF_WIDTH+DATA_WIDTH bits.
  - `left1 <= left_in`; `v1 <= 1`.
  - When `in_valid` = 0: `prod1`/`left1` hold and `v1 <= 0`.
- **Stage 2** (on `v1` = 1):
  - `r = (prod1 + RND) >>> FRAC_BITS` (arithmetic shift), where `RND = 2^(FRAC_BITS-1)` if ROUND=1 and FRAC_BITS>0, else 0.
  - `s = sext(left1) + r`, computed at `max(COEF_WIDTH+DATA_WIDTH, OUT_WIDTH) + 2` bits; no intermediate truncation.
  - If `s` is outside `[-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]`:
    - `ovf_flag <= 1`.
    - `partial_out` becomes the clamped bound (SATURATE=1) or `s[OUT_WIDTH-1:0]` (SATURATE=0).
  - If `s` is in range: `partial_out <= s`.
  - `out_valid <= 1`.
  - When `v1` = 0: `partial_out` holds and `out_valid <= 0`.
- **Latency:** `partial_out`/`out_valid` appear 2 cycles after the `in_valid` edge. The array controller skews operands accordingly; this block does not re-align them.
- **Throughput:** one sample per cycle; back-to-back `in_valid` with a different `coef_sel` each cycle is fully supported.
- **`clear`** (synchronous, priority over `in_valid` and `v1`):
  - Next edge: `v1`, `down_valid`, `out_valid` and `ovf_flag` go to 0.
  - Data registers and the bank hold.
  - A sample presented with `clear` = 1 is dropped.
  - A `clear` and a bank write in the same cycle both take effect.
- **Sticky flag:** `ovf_flag` is cleared only by reset or `clear`. If `clear` and an overflow coincide, `clear` wins.
- **Bubbles:** idle cycles never modify `partial_out`/`down_out` values, only the valid bits.

Test Plan:
1. Defaults; write bank[0] = 0x00018000 (1.5); `in_valid` with top = 100, left = 10, sel = 0 → cycle+1: `down_out` = 100, `down_valid` = 1; cycle+2: `partial_out` = 160, `out_valid` = 1, `ovf_flag` = 0.
2. Rounding: bank[1] = 0x00008000 (0.5), left = 0, sel = 1:
   - top = 3 → 2 (ROUND=1) or 1 (ROUND=0).
   - top = -3 → -1 (ROUND=1) or -2 (ROUND=0).
3. Saturation: bank[2] = 0x7FFF0000, top = 2, left = 0 → 32767 and `ovf_flag` = 1. Then bank[3] = 0xFFFF0000 (-1.0), top = 1, left = -32768 → -32768. With SATURATE=0, the first case gives -2 (wrap).
4. Streaming: load bank = {1.0, 2.0, -1.0, 0.5}; 8 back-to-back samples, top = 40, left = 0, sel cycling 0..3 → `partial_out` = 40, 80, -40, 20 repeated, `out_valid` held high for 8 cycles, no gaps. Include one mid-stream bubble → `out_valid` low exactly one cycle, `partial_out` held.
5. Collision: bank[0] = 1.0; same cycle write bank[0] = 3.0 with `in_valid`, sel = 0, top = 5 → result 5. Next sample, top = 5 → 15.
6. `clear`/reset: assert `clear` with 2 samples in flight → no `out_valid` pulses, `ovf_flag` = 0, bank retained. Drop `aresetn` mid-stream → all outputs 0 immediately (asynchronous); bank reads 0 after release.
